// File: rtl/hand_pos_controller_pkg.sv
// Shared widths, init/limit constants and the point type for the hand position controller.
// Also holds the saturating step helper used by both axes.
package hand_pos_controller_pkg;

  localparam int COORD_W = 32'd12;
  localparam int DEPTH_W = 32'd14;
  localparam int CALC_W  = 32'd13;

  localparam logic [COORD_W-1:0] STEP     = 12'd4;
  localparam logic [COORD_W-1:0] X_INIT   = 12'd512;
  localparam logic [COORD_W-1:0] Y_INIT   = 12'd384;
  localparam logic [DEPTH_W-1:0] Z_INIT   = 14'd4096;
  localparam logic [COORD_W-1:0] X_MIN    = 12'd0;
  localparam logic [COORD_W-1:0] X_MAX    = 12'd1023;
  localparam logic [COORD_W-1:0] Y_MAX    = 12'd767;
  localparam logic [COORD_W-1:0] HAND_LEN = 12'd64;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DEPTH_W-1:0] z;
  } point_t;

  // One STEP move toward dec/inc, saturating at [lo, hi]; the 13-bit compare cannot wrap.
  function automatic logic [COORD_W-1:0] clamp_step(
    input logic [COORD_W-1:0] pos,
    input logic               dec,
    input logic               inc,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    logic [CALC_W-1:0] w_pos;
    logic [CALC_W-1:0] w_step;
    logic [CALC_W-1:0] w_up;
    w_pos  = {1'b0, pos};
    w_step = {1'b0, STEP};
    w_up   = w_pos + w_step;
    if (dec && !inc) begin
      clamp_step = (w_pos < ({1'b0, lo} + w_step)) ? lo : (pos - STEP);
    end else if (inc && !dec) begin
      clamp_step = (w_up > {1'b0, hi}) ? hi : w_up[COORD_W-1:0];
    end else begin
      clamp_step = pos;
    end
  endfunction

endpackage

// File: rtl/hand_pos_controller_if.sv
// Button inputs and X/Y/Z point outputs of the hand position controller.
// The camera tracker will later drive the same output set.
interface hand_pos_controller_if;
  import hand_pos_controller_pkg::*;

  logic               left_button;
  logic               right_button;
  logic               up_button;
  logic               down_button;
  logic [COORD_W-1:0] hand_x_left_bottom;
  logic [COORD_W-1:0] hand_y_left_bottom;
  logic [DEPTH_W-1:0] hand_z_left_bottom;
  logic [COORD_W-1:0] hand_x_left_top;
  logic [COORD_W-1:0] hand_y_left_top;
  logic [DEPTH_W-1:0] hand_z_left_top;

  modport master (
    output left_button, right_button, up_button, down_button,
    input  hand_x_left_bottom, hand_y_left_bottom, hand_z_left_bottom,
    input  hand_x_left_top, hand_y_left_top, hand_z_left_top
  );

  modport slave (
    input  left_button, right_button, up_button, down_button,
    output hand_x_left_bottom, hand_y_left_bottom, hand_z_left_bottom,
    output hand_x_left_top, hand_y_left_top, hand_z_left_top
  );

endinterface

// File: rtl/hand_pos_controller_button_edge.sv
// Two-flop synchronizer plus rising-edge detector: one press pulse per low-to-high transition.
module button_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the raw button and keep the previous synchronized level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/hand_pos_controller.sv
// Button-driven stand-in for a tracked left hand: keeps the bottom point, derives the top point.
module hand_pos_controller
  import hand_pos_controller_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  hand_pos_controller_if.slave  bus
);

  logic   w_left;
  logic   w_right;
  logic   w_up;
  logic   w_down;
  point_t r_bottom;
  point_t w_next;

  button_edge u_left  (.i_clk(clk_in), .i_rst(rst_in), .i_btn(bus.left_button),  .o_press(w_left));
  button_edge u_right (.i_clk(clk_in), .i_rst(rst_in), .i_btn(bus.right_button), .o_press(w_right));
  button_edge u_up    (.i_clk(clk_in), .i_rst(rst_in), .i_btn(bus.up_button),    .o_press(w_up));
  button_edge u_down  (.i_clk(clk_in), .i_rst(rst_in), .i_btn(bus.down_button),  .o_press(w_down));

  // Next bottom point; y floor is HAND_LEN so the top point never goes negative.
  always_comb begin
    w_next   = r_bottom;
    w_next.x = clamp_step(r_bottom.x, w_left, w_right, X_MIN, X_MAX);
    w_next.y = clamp_step(r_bottom.y, w_up, w_down, HAND_LEN, Y_MAX);
    w_next.z = Z_INIT;
  end

  // Bottom point register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bottom <= '{x: X_INIT, y: Y_INIT, z: Z_INIT};
    end else begin
      r_bottom <= w_next;
    end
  end

  assign bus.hand_x_left_bottom = r_bottom.x;
  assign bus.hand_y_left_bottom = r_bottom.y;
  assign bus.hand_z_left_bottom = r_bottom.z;
  assign bus.hand_x_left_top    = r_bottom.x;
  assign bus.hand_y_left_top    = r_bottom.y - HAND_LEN;
  assign bus.hand_z_left_top    = Z_INIT;

endmodule

// File: tb/tb_hand_pos_controller.sv
// Directed self-checking bench for hand_pos_controller: reset, single presses, clamping, async reset.
module tb_hand_pos_controller;

  logic clk_in;
  logic rst_in;
  int   total;
  int   bad;
  int   exp_x;
  int   exp_y;

  hand_pos_controller_if bus ();

  hand_pos_controller dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_point(input string tag, input int bx, input int by);
    chk({tag, "_bx"}, int'(bus.hand_x_left_bottom), bx);
    chk({tag, "_by"}, int'(bus.hand_y_left_bottom), by);
    chk({tag, "_bz"}, int'(bus.hand_z_left_bottom), 4096);
    chk({tag, "_tx"}, int'(bus.hand_x_left_top), bx);
    chk({tag, "_ty"}, int'(bus.hand_y_left_top), by - 64);
    chk({tag, "_tz"}, int'(bus.hand_z_left_top), 4096);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_in = 1'b1;
    bus.left_button  = 1'b0;
    bus.right_button = 1'b0;
    bus.up_button    = 1'b0;
    bus.down_button  = 1'b0;
    tick();
    tick();
    chk_point("reset", 512, 384);
    rst_in = 1'b0;
    tick();
    tick();
    chk_point("idle", 512, 384);

    // single left press: sampled at edge k, visible after edge k+2
    bus.left_button = 1'b1;
    tick();
    bus.left_button = 1'b0;
    tick();
    chk("lat_k1_x", int'(bus.hand_x_left_bottom), 512);
    tick();
    chk_point("one_left", 508, 384);

    // 2000 alternating pulses; each check lags the newest press by one edge
    exp_x = 508;
    for (int i = 0; i < 2000; i++) begin
      bus.left_button = 1'b1;
      tick();
      bus.left_button = 1'b0;
      tick();
      chk("pulse_x", int'(bus.hand_x_left_bottom), exp_x);
      chk("pulse_by", int'(bus.hand_y_left_bottom), 384);
      chk("pulse_ty", int'(bus.hand_y_left_top), 320);
      exp_x = (exp_x < 4) ? 0 : exp_x - 4;
    end
    tick();
    tick();
    chk_point("left_floor", 0, 384);

    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    chk_point("rst2", 512, 384);

    // right held for 50 cycles is a single press
    bus.right_button = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    bus.right_button = 1'b0;
    tick();
    tick();
    chk_point("right_hold", 516, 384);

    bus.left_button  = 1'b1;
    bus.right_button = 1'b1;
    tick();
    bus.left_button  = 1'b0;
    bus.right_button = 1'b0;
    tick();
    tick();
    tick();
    chk_point("left_right", 516, 384);

    bus.left_button = 1'b1;
    bus.up_button   = 1'b1;
    tick();
    bus.left_button = 1'b0;
    bus.up_button   = 1'b0;
    tick();
    tick();
    chk_point("diag", 512, 380);

    exp_y = 380;
    for (int i = 0; i < 200; i++) begin
      bus.down_button = 1'b1;
      tick();
      bus.down_button = 1'b0;
      tick();
      tick();
      exp_y = (exp_y + 4 > 767) ? 767 : exp_y + 4;
      chk("down_y", int'(bus.hand_y_left_bottom), exp_y);
    end
    chk_point("down_ceil", 512, 767);

    for (int i = 0; i < 200; i++) begin
      bus.up_button = 1'b1;
      tick();
      bus.up_button = 1'b0;
      tick();
      tick();
      exp_y = (exp_y < 68) ? 64 : exp_y - 4;
      chk("up_y", int'(bus.hand_y_left_bottom), exp_y);
    end
    chk_point("up_floor", 512, 64);

    // asynchronous reset takes effect between clock edges
    rst_in = 1'b1;
    #1;
    chk_point("async_rst", 512, 384);
    tick();
    rst_in = 1'b0;
    tick();
    chk_point("post_rst", 512, 384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
